// File: rtl/digital_filter_pkg.sv
// Shared sizing helpers and default-width types for the digital_filter FIR slice.
package digital_filter_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_COEFF_WIDTH = 16;
   localparam int DEF_NUM_TAPS    = 32;

   // Wide enough that NUM_TAPS full-scale products can never overflow.
   function automatic int acc_width(input int data_width, input int coeff_width, input int num_taps);
      return data_width + coeff_width + $clog2(num_taps);
   endfunction

   function automatic longint round_const(input int coeff_width);
      return longint'(1) << (coeff_width - 2);
   endfunction

   typedef logic signed [DEF_DATA_WIDTH-1:0]  sample_t;
   typedef logic signed [DEF_COEFF_WIDTH-1:0] coeff_t;
   typedef logic signed [acc_width(DEF_DATA_WIDTH, DEF_COEFF_WIDTH, DEF_NUM_TAPS)-1:0] acc_t;

endpackage

// File: rtl/digital_filter_round_sat.sv
// Rounds and rescales the FIR accumulator back to sample width.
// Clamps when DIGITAL_FILTER_SAT_EN is defined, otherwise wraps.
module digital_filter_round_sat
   import digital_filter_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int ACC_WIDTH   = 37
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   output logic signed [DATA_WIDTH-1:0] y
);

   localparam int EXT_WIDTH = ACC_WIDTH + 1;
   localparam logic signed [EXT_WIDTH-1:0] ROUND = EXT_WIDTH'(round_const(COEFF_WIDTH));

   logic signed [EXT_WIDTH-1:0] rounded;
   logic signed [EXT_WIDTH-1:0] shifted;

   // Round half up, then arithmetic shift out the Q1 fraction bits.
   assign rounded = EXT_WIDTH'(acc) + ROUND;
   assign shifted = rounded >>> (COEFF_WIDTH - 1);

`ifdef DIGITAL_FILTER_SAT_EN
   localparam logic signed [EXT_WIDTH-1:0] SAT_MAX =
      {{(EXT_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_WIDTH-1:0] SAT_MIN =
      {{(EXT_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   always_comb begin
      y = shifted[DATA_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         y = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         y = SAT_MIN[DATA_WIDTH-1:0];
      end
   end
`else
   logic unused_high_bits;

   assign unused_high_bits = ^shifted[EXT_WIDTH-1:DATA_WIDTH];
   assign y = shifted[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/digital_filter.sv
// Direct-form FIR filter with live coefficient inputs and a registered output.
// Optional output saturation via DIGITAL_FILTER_SAT_EN (default build wraps).
module digital_filter
   import digital_filter_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_TAPS    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [DATA_WIDTH-1:0]  data_in,
   input  logic signed [COEFF_WIDTH-1:0] coeff [NUM_TAPS],
   output logic signed [DATA_WIDTH-1:0]  data_out
);

   localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
   localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

   logic signed [DATA_WIDTH-1:0] taps [NUM_TAPS];
   logic signed [PROD_WIDTH-1:0] prod [NUM_TAPS];
   logic signed [ACC_WIDTH-1:0]  psum [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] y;

   // Tap 0 is the live input; only the older samples are registered.
   assign taps[0] = data_in;

   generate
      if (NUM_TAPS > 1) begin : g_delay
         logic signed [DATA_WIDTH-1:0] dline [1:NUM_TAPS-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 1; k < NUM_TAPS; k++) begin
                  dline[k] <= '0;
               end
            end else begin
               dline[1] <= data_in;
               for (int k = 2; k < NUM_TAPS; k++) begin
                  dline[k] <= dline[k-1];
               end
            end
         end

         for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
            assign taps[k] = dline[k];
         end
      end
   endgenerate

   // Multiply-accumulate as a sign-extended adder chain.
   generate
      for (genvar k = 0; k < NUM_TAPS; k++) begin : g_mac
         assign prod[k] = taps[k] * coeff[k];
         if (k == 0) begin : g_first
            assign psum[k] = ACC_WIDTH'(prod[k]);
         end else begin : g_rest
            assign psum[k] = psum[k-1] + ACC_WIDTH'(prod[k]);
         end
      end
   endgenerate

   digital_filter_round_sat #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
   ) u_round_sat (
      .acc (psum[NUM_TAPS-1]),
      .y   (y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else begin
         data_out <= y;
      end
   end

endmodule

// File: tb/tb_digital_filter.sv
// Randomised and directed self-checking bench for digital_filter against an arithmetic FIR model.
module tb_digital_filter;

   localparam int NT = 32;

   logic                clk;
   logic                rst;
   logic signed [15:0]  data_in;
   logic signed [15:0]  coeff [NT];
   logic signed [15:0]  data_out;

   logic signed [15:0]  past [NT];
   int                  checks;
   int                  failures;

   digital_filter #(
      .DATA_WIDTH  (16),
      .COEFF_WIDTH (16),
      .NUM_TAPS    (NT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .coeff    (coeff),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: y = round(sum(coeff[k]*x[n-k]) / 2^15), then clamp or wrap to 16 bits.
   function automatic logic signed [15:0] model(input logic signed [15:0] din);
      longint acc;
      longint y;
      logic signed [15:0] s;
      acc = 0;
      for (int k = 0; k < NT; k++) begin
         s = (k == 0) ? din : past[k];
         acc += longint'(coeff[k]) * longint'(s);
      end
      y = (acc + 64'sd16384) >>> 15;
`ifdef DIGITAL_FILTER_SAT_EN
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
`endif
      return y[15:0];
   endfunction

   task automatic checkOutput(input string tag, input logic signed [15:0] act, input logic signed [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: data_out=%0d (0x%04h) expected=%0d (0x%04h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic clearHistory();
      for (int k = 0; k < NT; k++) past[k] = '0;
   endtask

   // Called at a falling edge; leaves the bench at the next falling edge.
   task automatic applyStimulus(input string tag, input logic signed [15:0] din);
      logic signed [15:0] exp;
      rst     = 1'b0;
      data_in = din;
      exp     = model(din);
      @(posedge clk);
      #1;
      for (int k = NT - 1; k >= 2; k--) past[k] = past[k-1];
      past[1] = din;
      checkOutput(tag, data_out, exp);
      @(negedge clk);
   endtask

   task automatic applyReset(input logic signed [15:0] din);
      rst     = 1'b1;
      data_in = din;
      @(posedge clk);
      #1;
      clearHistory();
      checkOutput("reset_hold", data_out, 16'sd0);
      @(negedge clk);
   endtask

   task automatic setAllCoeff(input logic signed [15:0] c);
      for (int k = 0; k < NT; k++) coeff[k] = c;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clearHistory();
      setAllCoeff(16'sd0);
      data_in = '0;
      rst     = 1'b1;
      #1;
      checkOutput("reset_async", data_out, 16'sd0);
      @(negedge clk);

      // Reset held with toggling input.
      setAllCoeff(16'sh7FFF);
      for (int i = 0; i < 5; i++) applyReset((i % 2 == 0) ? 16'sh1234 : 16'sh5678);

      // First post-reset output: only the current sample counts.
      for (int k = 0; k < NT; k++) coeff[k] = 16'(k + 1);
      applyStimulus("post_reset", 16'sh4000);
      checkOutput("post_reset_val", data_out, 16'sd1);

      // Impulse response walks through the coefficients, then decays to 0.
      for (int i = 0; i < NT + 2; i++) applyStimulus("impulse", 16'sd0);
      checkOutput("impulse_tail", data_out, 16'sd0);

      // Pass-through with near-unity tap 0.
      setAllCoeff(16'sd0);
      coeff[0] = 16'sh7FFF;
      applyStimulus("pass_pos", 16'sd1000);
      checkOutput("pass_pos_val", data_out, 16'sd1000);
      applyStimulus("pass_neg", -16'sd1000);
      checkOutput("pass_neg_val", data_out, -16'sd1000);

      // Moving average of 32 samples settles at the input level.
      setAllCoeff(16'sh0400);
      for (int i = 0; i < NT + 2; i++) applyStimulus("average", 16'sd3200);
      checkOutput("average_settle", data_out, 16'sd3200);

      // Full-scale overflow: clamp or wrap.
      setAllCoeff(16'sh7FFF);
      for (int i = 0; i < NT + 1; i++) applyStimulus("ovf_pos", 16'sh7FFF);
`ifdef DIGITAL_FILTER_SAT_EN
      checkOutput("ovf_pos_sat", data_out, 16'sh7FFF);
`else
      checkOutput("ovf_pos_wrap", data_out, -16'sd64);
`endif
      for (int i = 0; i < NT + 1; i++) applyStimulus("ovf_neg", 16'sh8000);
`ifdef DIGITAL_FILTER_SAT_EN
      checkOutput("ovf_neg_sat", data_out, 16'sh8000);
`endif

      // Asynchronous reset between edges in the middle of averaging.
      setAllCoeff(16'sh0400);
      for (int i = 0; i < 10; i++) applyStimulus("avg_pre_rst", 16'sd3200);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_midstream", data_out, 16'sd0);
      clearHistory();
      @(negedge clk);
      applyReset(16'sd3200);
      applyStimulus("restart", 16'sd3200);
      checkOutput("restart_val", data_out, 16'sd100);
      for (int i = 0; i < 5; i++) applyStimulus("restart_ramp", 16'sd3200);

      // All-zero coefficients block any input.
      setAllCoeff(16'sd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus("zero_coeff", 16'($urandom));
         checkOutput("zero_coeff_val", data_out, 16'sd0);
      end

      // Random data with coefficients reprogrammed on the fly.
      for (int k = 0; k < NT; k++) coeff[k] = 16'($urandom_range(0, 2047)) - 16'sd1024;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) coeff[$urandom_range(0, NT - 1)] = 16'($urandom);
         applyStimulus("random", 16'($urandom));
      end

      // Random full-range coefficients exercise overflow handling.
      for (int i = 0; i < 100; i++) begin
         for (int k = 0; k < NT; k++) coeff[k] = 16'($urandom);
         applyStimulus("random_full", 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
